// File: rtl/cordic_pkg.sv
// cordic_pkg: command-word field positions, fixed-point constants and the
// decoded-command layout shared by the CORDIC input stage.
package cordic_pkg;
    localparam int OP_LSB      = 0;
    localparam int OP_MSB      = 15;
    localparam int ARCTAN_BIT  = 16;
    localparam int XLOAD_BIT   = 17;
    localparam int P90_DEFAULT = 23040;
    localparam int CMD_WIDTH   = 16;
    localparam logic [CMD_WIDTH-1:0] ONE = 16'h0100;

    typedef struct packed {
        logic [CMD_WIDTH-1:0] degree;
        logic [CMD_WIDTH-1:0] x;
        logic [CMD_WIDTH-1:0] y;
        logic                 flip;
        logic                 arctan_en;
    } cmd_t;
endpackage

// File: rtl/cordic_cmd_fifo.sv
// cordic_cmd_fifo: synchronous FIFO with occupancy output and the head entry
// read straight from the storage registers.
module cordic_cmd_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DW-1:0]            wr_data,
    input  logic                     pop,
    output logic [DW-1:0]            head,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;
endmodule

// File: rtl/cordic_input_stage.sv
// cordic_input_stage: decodes command words into rotation/vectoring operands
// with quadrant folding, holds the atan2 x operand and queues entries for the core.
module cordic_input_stage
    import cordic_pkg::*;
#(
    parameter int WIDTH      = CMD_WIDTH,
    parameter int FRAC_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int ANGLE_P90  = P90_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            in_word,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       degree_out,
    output logic [WIDTH-1:0]       x_out,
    output logic [WIDTH-1:0]       y_out,
    output logic                   flip_out,
    output logic                   arctan_en_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic signed [WIDTH+1:0] P90     = (WIDTH+2)'(ANGLE_P90);
    localparam logic signed [WIDTH+1:0] NEG_P90 = -P90;
    localparam logic signed [WIDTH+1:0] TWO_P90 = (WIDTH+2)'(2 * ANGLE_P90);
    localparam logic [WIDTH-1:0]        ONE_W   = WIDTH'(1) << FRAC_WIDTH;

    logic [WIDTH-1:0]        op, x_hold_q, x_hold_d;
    logic signed [WIDTH+1:0] op_w;
    logic                    accept, xload, arctan, push, pop, fold_hi, fold_lo;
    logic                    unused_bits;
    cmd_t                    entry, head;

    assign unused_bits = ^in_word[31:18];

    // Folding is done two bits wider so op +/- 2*P90 cannot overflow before truncation.
    always_comb begin
        op              = in_word[OP_MSB:OP_LSB];
        op_w            = {{2{op[WIDTH-1]}}, op};
        xload           = in_word[XLOAD_BIT];
        arctan          = in_word[ARCTAN_BIT];
        fold_hi         = op_w > P90;
        fold_lo         = op_w < NEG_P90;
        accept          = in_valid & in_ready;
        push            = accept & ~xload;
        pop             = out_valid & out_ready;
        x_hold_d        = !accept ? x_hold_q : xload ? op : arctan ? ONE_W : x_hold_q;
        entry.degree    = arctan ? '0 : WIDTH'(fold_hi ? op_w - TWO_P90 : fold_lo ? op_w + TWO_P90 : op_w);
        entry.x         = arctan ? x_hold_q : ONE_W;
        entry.y         = arctan ? op : '0;
        entry.flip      = arctan ? x_hold_q[WIDTH-1] : (fold_hi | fold_lo);
        entry.arctan_en = arctan;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) x_hold_q <= ONE_W;
        else        x_hold_q <= x_hold_d;
    end

    cordic_cmd_fifo #(.DW($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (entry),
        .pop     (pop),
        .head    (head),
        .level   (level)
    );

    assign in_ready      = level < LW'(DEPTH);
    assign out_valid     = level != '0;
    assign degree_out    = head.degree;
    assign x_out         = head.x;
    assign y_out         = head.y;
    assign flip_out      = head.flip;
    assign arctan_en_out = head.arctan_en;
endmodule
